mem_port_arbiter: RTL and testbench

- Shares the single external memory port between three requesters: decompressor ifmap reads, weight-loader reads and compressor writebacks.
- Generates a streaming address per requester from per-layer base addresses.
- Serialises transactions: at most one outstanding.
- Returns read data or write acknowledgements to the owner.
- Sits between the top-level memory pins and the decompressor, weight path and compressor.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter_rr_arbiter3.sv | 28 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    RESP
  } mem_port_state_e;

  typedef enum logic [1:0] {
    REQ_DEC,
    REQ_WT,
    REQ_CMP
  } mem_requester_e;

  localparam int unsigned BEAT_BYTES = 8;

  function automatic mem_requester_e rr_next(input mem_requester_e r);
    case (r)
      REQ_DEC: return REQ_WT;
      REQ_WT:  return REQ_CMP;
      default: return REQ_DEC;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              dec_req;
  logic              wt_req;
  logic              cmp_req;
  logic [DATA_W-1:0] cmp_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] rd_data;
  logic              dec_data_valid;
  logic              wt_data_valid;
  logic              cmp_ack;

  modport slave (
    input  dec_req, wt_req, cmp_req, cmp_data, mem_read_data, mem_valid,
    output mem_addr, mem_write_data, mem_read, mem_write, rd_data,
           dec_data_valid, wt_data_valid, cmp_ack
  );

  modport master (
    output dec_req, wt_req, cmp_req, cmp_data, mem_read_data, mem_valid,
    input  mem_addr, mem_write_data, mem_read, mem_write, rd_data,
           dec_data_valid, wt_data_valid, cmp_ack
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin: search starts at ptr, next_ptr follows the winner.
module rr_arbiter3
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]     req,
  input  mem_requester_e ptr,
  output logic [2:0]     grant,
  output mem_requester_e next_ptr
);

  always_comb begin
    mem_requester_e idx;
    logic           found;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = ptr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = rr_next(idx);
        found      = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises ifmap reads, weight reads and compressor writebacks onto one
// memory port, one transaction outstanding, with per-requester address streams.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned BEAT_BYTES = mem_port_arbiter_pkg::BEAT_BYTES,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    ifmap_base_addr,
  input  logic [ADDR_W-1:0]    weight_base_addr,
  input  logic [ADDR_W-1:0]    wb_base_addr,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic                 error
);
  import mem_port_arbiter_pkg::*;

  localparam int unsigned    TW     = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(RD_TIMEOUT - 1);

  mem_port_state_e   state, state_next;
  mem_requester_e    rr_ptr, rr_ptr_next, owner, winner;
  logic [2:0]        req_vec, grant;
  logic [ADDR_W-1:0] dec_ptr, wt_ptr, wb_ptr;
  logic [TW-1:0]     tcnt;
  logic              timeout_hit, stray;
  logic              mem_read_n, mem_write_n, dec_v_n, wt_v_n, cmp_ack_n, error_n;
  logic              mem_read_q, mem_write_q, dec_v_q, wt_v_q, cmp_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rd_data_q;

  assign req_vec = {bus.cmp_req, bus.wt_req, bus.dec_req};

  rr_arbiter3 u_rr (
    .req      (req_vec),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_ptr_next)
  );

  always_comb begin
    winner = REQ_DEC;
    if (grant[1])      winner = REQ_WT;
    else if (grant[2]) winner = REQ_CMP;
  end

  assign timeout_hit = (state == RD_WAIT) && !bus.mem_valid && (tcnt == T_LAST) && !start;
  // Data arriving with a start pulse belongs to an abandoned read, so it is stray too.
  assign stray       = bus.mem_valid && ((state != RD_WAIT) || start);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (|grant) state_next = grant[2] ? WR : RD_ISSUE;
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_valid)    state_next = RESP;
        else if (timeout_hit) state_next = IDLE;
      end
      WR:       state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (start) state_next = IDLE;
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    mem_read_n  = (state_next == RD_ISSUE);
    mem_write_n = (state_next == WR);
    dec_v_n     = (state_next == RESP) && (state == RD_WAIT) && (owner == REQ_DEC);
    wt_v_n      = (state_next == RESP) && (state == RD_WAIT) && (owner == REQ_WT);
    cmp_ack_n   = (state_next == RESP) && (state == WR);
    error_n     = timeout_hit || stray;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      dec_v_q     <= 1'b0;
      wt_v_q      <= 1'b0;
      cmp_ack_q   <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      mem_read_q  <= mem_read_n;
      mem_write_q <= mem_write_n;
      dec_v_q     <= dec_v_n;
      wt_v_q      <= wt_v_n;
      cmp_ack_q   <= cmp_ack_n;
      busy        <= (state_next != IDLE);
      error       <= error_n;
      if (state_next == RD_ISSUE) begin
        mem_addr_q <= (winner == REQ_WT) ? wt_ptr : dec_ptr;
      end else if (state_next == WR) begin
        mem_addr_q  <= wb_ptr;
        mem_wdata_q <= bus.cmp_data;
      end
      if ((state == RD_WAIT) && bus.mem_valid && !start) rd_data_q <= bus.mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= REQ_DEC;
      owner   <= REQ_DEC;
      dec_ptr <= '0;
      wt_ptr  <= '0;
      wb_ptr  <= '0;
      tcnt    <= '0;
    end else begin
      if (start || (state != RD_WAIT)) tcnt <= '0;
      else                             tcnt <= tcnt + TW'(1);
      if (start) begin
        dec_ptr <= ifmap_base_addr;
        wt_ptr  <= weight_base_addr;
        wb_ptr  <= wb_base_addr;
      end else begin
        if ((state == IDLE) && (|grant)) begin
          rr_ptr <= rr_ptr_next;
          owner  <= winner;
        end
        if ((state == RD_WAIT) && bus.mem_valid) begin
          if (owner == REQ_WT) wt_ptr  <= wt_ptr + ADDR_W'(BEAT_BYTES);
          else                 dec_ptr <= dec_ptr + ADDR_W'(BEAT_BYTES);
        end
        if (state == WR) wb_ptr <= wb_ptr + ADDR_W'(BEAT_BYTES);
      end
    end
  end

  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.dec_data_valid = dec_v_q;
  assign bus.wt_data_valid  = wt_v_q;
  assign bus.cmp_ack        = cmp_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector tables plus hand-written corner sequences.
module tb_mem_port_arbiter;

  typedef struct {
    logic        dec, wt, cmp, mv;
    logic [63:0] rdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr;
    logic        e_dv, e_wv, e_ack, e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] ifmap_base, weight_base, wb_base;
  logic        busy, error;
  logic [63:0] tbl_cdata;
  vec_t        vecs[$];
  int          checks = 0;
  int          passes = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(64), .BEAT_BYTES(8), .RD_TIMEOUT(255)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .ifmap_base_addr  (ifmap_base),
    .weight_base_addr (weight_base),
    .wb_base_addr     (wb_base),
    .bus              (bus),
    .busy             (busy),
    .error            (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dec_req = 1'b0; bus.wt_req = 1'b0; bus.cmp_req = 1'b0;
    bus.cmp_data = '0; bus.mem_valid = 1'b0; bus.mem_read_data = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " mem_read"}, 64'(bus.mem_read), 0);
    check({tag, " mem_write"}, 64'(bus.mem_write), 0);
    check({tag, " mem_addr"}, 64'(bus.mem_addr), 0);
    check({tag, " mem_write_data"}, bus.mem_write_data, 0);
    check({tag, " rd_data"}, bus.rd_data, 0);
    check({tag, " valids/ack"}, 64'({bus.dec_data_valid, bus.wt_data_valid, bus.cmp_ack}), 0);
    check({tag, " busy"}, 64'(busy), 0);
    check({tag, " error"}, 64'(error), 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    start = 1'b0; rst = 1'b1;
    tick();
    check_reset_state("reset");
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic d, w, c, mv, input logic [63:0] rdat,
                      input logic erd, ewr, input logic [31:0] ea,
                      input logic edv, ewv, eack, ebusy);
    vec_t v;
    v.dec = d; v.wt = w; v.cmp = c; v.mv = mv; v.rdata = rdat;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea;
    v.e_dv = edv; v.e_wv = ewv; v.e_ack = eack; v.e_busy = ebusy;
    vecs.push_back(v);
  endtask

  // Each row drives inputs for one cycle; expectations are the outputs of the following cycle.
  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      bus.dec_req = vecs[i].dec; bus.wt_req = vecs[i].wt; bus.cmp_req = vecs[i].cmp;
      bus.mem_valid = vecs[i].mv; bus.mem_read_data = vecs[i].rdata; bus.cmp_data = tbl_cdata;
      tick();
      check($sformatf("%s[%0d] mem_read", tag, i), 64'(bus.mem_read), 64'(vecs[i].e_rd));
      check($sformatf("%s[%0d] mem_write", tag, i), 64'(bus.mem_write), 64'(vecs[i].e_wr));
      check($sformatf("%s[%0d] dec_valid", tag, i), 64'(bus.dec_data_valid), 64'(vecs[i].e_dv));
      check($sformatf("%s[%0d] wt_valid", tag, i), 64'(bus.wt_data_valid), 64'(vecs[i].e_wv));
      check($sformatf("%s[%0d] cmp_ack", tag, i), 64'(bus.cmp_ack), 64'(vecs[i].e_ack));
      check($sformatf("%s[%0d] busy", tag, i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("%s[%0d] error", tag, i), 64'(error), 0);
      if (vecs[i].e_rd || vecs[i].e_wr)
        check($sformatf("%s[%0d] mem_addr", tag, i), 64'(bus.mem_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_wr)
        check($sformatf("%s[%0d] wdata", tag, i), bus.mem_write_data, tbl_cdata);
      if (vecs[i].e_dv || vecs[i].e_wv)
        check($sformatf("%s[%0d] rd_data", tag, i), bus.rd_data, vecs[i - 1 + 1].rdata);
    end
    vecs.delete();
    clear_inputs();
  endtask

  // Single read with mem_valid in the first wait cycle.
  task automatic do_read(input logic is_wt, input logic [31:0] addr, input logic [63:0] data,
                         input string tag);
    bus.dec_req = !is_wt; bus.wt_req = is_wt;
    tick();
    check({tag, " mem_read"}, 64'(bus.mem_read), 1);
    check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(addr));
    bus.dec_req = 1'b0; bus.wt_req = 1'b0;
    tick();
    bus.mem_valid = 1'b1; bus.mem_read_data = data;
    tick();
    bus.mem_valid = 1'b0; bus.mem_read_data = '0;
    check({tag, " valid"}, 64'({bus.dec_data_valid, bus.wt_data_valid}), is_wt ? 64'd1 : 64'd2);
    check({tag, " rd_data"}, bus.rd_data, data);
    tick();
    check({tag, " idle"}, 64'(busy), 0);
  endtask

  task automatic do_write(input logic [63:0] data, input logic [31:0] addr, input string tag);
    bus.cmp_req = 1'b1; bus.cmp_data = data;
    tick();
    check({tag, " mem_write"}, 64'(bus.mem_write), 1);
    check({tag, " mem_read"}, 64'(bus.mem_read), 0);
    check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(addr));
    check({tag, " wdata"}, bus.mem_write_data, data);
    check({tag, " early ack"}, 64'(bus.cmp_ack), 0);
    bus.cmp_req = 1'b0; bus.cmp_data = '0;
    tick();
    check({tag, " cmp_ack"}, 64'(bus.cmp_ack), 1);
    check({tag, " strobe drop"}, 64'(bus.mem_write), 0);
    tick();
    check({tag, " ack drop"}, 64'(bus.cmp_ack), 0);
    check({tag, " idle"}, 64'(busy), 0);
  endtask

  initial begin
    int          to_cycles;
    logic        dv_seen;
    logic [31:0] a;

    clear_inputs();
    tbl_cdata = '0;
    ifmap_base = 32'h1000; weight_base = 32'h2000; wb_base = 32'h3000;

    // rst and start together: reset must win, pointers stay at zero.
    rst = 1'b1; start = 1'b1;
    tick();
    check_reset_state("rst+start");
    rst = 1'b0; start = 1'b0;
    do_read(1'b0, 32'h0, 64'h55, "ptr0 dec");
    do_read(1'b1, 32'h0, 64'h66, "ptr0 wt");
    do_write(64'h77, 32'h0, "ptr0 wb");

    // dec_req held, mem_valid three cycles after mem_read.
    do_reset();
    do_start();
    for (int unsigned b = 0; b < 3; b++) begin
      a = 32'h1000 + 32'(8 * b);
      push(1, 0, 0, 0, 0,                     1, 0, a,    0, 0, 0, 1);
      push(1, 0, 0, 0, 0,                     0, 0, 0,    0, 0, 0, 1);
      push(1, 0, 0, 0, 0,                     0, 0, 0,    0, 0, 0, 1);
      push(1, 0, 0, 0, 0,                     0, 0, 0,    0, 0, 0, 1);
      push(1, 0, 0, 1, 64'hA5A5_0000_0000_0000 + 64'(b), 0, 0, 0, 1, 0, 0, 1);
      push(1, 0, 0, 0, 0,                     0, 0, 0,    0, 0, 0, 0);
    end
    run_table("stream");

    // All three requesting: grants dec, wt, cmp, dec.
    do_reset();
    do_start();
    tbl_cdata = 64'h0123_4567_89AB_CDEF;
    push(1, 1, 1, 0, 0,        1, 0, 32'h1000, 0, 0, 0, 1);
    push(1, 1, 1, 0, 0,        0, 0, 0,        0, 0, 0, 1);
    push(1, 1, 1, 1, 64'hD0,   0, 0, 0,        1, 0, 0, 1);
    push(1, 1, 1, 0, 0,        0, 0, 0,        0, 0, 0, 0);
    push(1, 1, 1, 0, 0,        1, 0, 32'h2000, 0, 0, 0, 1);
    push(1, 1, 1, 0, 0,        0, 0, 0,        0, 0, 0, 1);
    push(1, 1, 1, 1, 64'hD1,   0, 0, 0,        0, 1, 0, 1);
    push(1, 1, 1, 0, 0,        0, 0, 0,        0, 0, 0, 0);
    push(1, 1, 1, 0, 0,        0, 1, 32'h3000, 0, 0, 0, 1);
    push(1, 1, 1, 0, 0,        0, 0, 0,        0, 0, 1, 1);
    push(1, 1, 1, 0, 0,        0, 0, 0,        0, 0, 0, 0);
    push(1, 1, 1, 0, 0,        1, 0, 32'h1008, 0, 0, 0, 1);
    run_table("rr");
    do_start();
    check("rr abort busy", 64'(busy), 0);

    // Compressor writeback stream.
    do_reset();
    do_start();
    do_write(64'hDEADBEEF_CAFEF00D, 32'h3000, "wr0");
    do_write(64'h1122_3344_5566_7788, 32'h3008, "wr1");

    // Read timeout and retry of the same address.
    do_reset();
    do_start();
    bus.dec_req = 1'b1;
    tick();
    check("to mem_read", 64'(bus.mem_read), 1);
    check("to mem_addr", 64'(bus.mem_addr), 64'h1000);
    to_cycles = 0;
    dv_seen = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (bus.dec_data_valid) dv_seen = 1'b1;
      if (error) begin
        to_cycles = c;
        break;
      end
    end
    check("to latency", 64'(to_cycles), 256);
    check("to no valid", 64'(dv_seen), 0);
    check("to busy", 64'(busy), 0);
    tick();
    check("to error pulse", 64'(error), 0);
    check("to retry read", 64'(bus.mem_read), 1);
    check("to retry addr", 64'(bus.mem_addr), 64'h1000);
    bus.dec_req = 1'b0;
    do_start();

    // Stray mem_valid in IDLE and after an abandoned read.
    do_reset();
    do_start();
    bus.mem_valid = 1'b1; bus.mem_read_data = 64'h1111;
    tick();
    bus.mem_valid = 1'b0;
    check("stray idle error", 64'(error), 1);
    check("stray idle valid", 64'({bus.dec_data_valid, bus.wt_data_valid}), 0);
    tick();
    check("stray idle pulse", 64'(error), 0);
    bus.dec_req = 1'b1;
    tick();
    check("abandon mem_read", 64'(bus.mem_read), 1);
    bus.dec_req = 1'b0;
    tick();
    tick();
    ifmap_base = 32'h5000; weight_base = 32'h6000; wb_base = 32'h7000;
    do_start();
    check("abandon busy", 64'(busy), 0);
    check("abandon error", 64'(error), 0);
    bus.mem_valid = 1'b1; bus.mem_read_data = 64'h2222;
    tick();
    bus.mem_valid = 1'b0;
    check("late error", 64'(error), 1);
    check("late valid", 64'({bus.dec_data_valid, bus.wt_data_valid}), 0);
    check("late rd_data", bus.rd_data, 0);
    do_read(1'b0, 32'h5000, 64'h33, "reload dec");
    do_read(1'b1, 32'h6000, 64'h44, "reload wt");
    do_write(64'h88, 32'h7000, "reload wb");

    // Writeback pointer wraps at the top of the address space.
    do_reset();
    wb_base = 32'hFFFF_FFF8;
    do_start();
    do_write(64'hAAAA, 32'hFFFF_FFF8, "wrap0");
    do_write(64'hBBBB, 32'h0000_0000, "wrap1");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
